alu_muldiv_seq: RTL and testbench

- Multi-cycle controller that runs 8x8 unsigned multiply and 8/8 unsigned divide on the shared 8-bit ALU.
- Drives the ALU's operand, opcode and shift-amount inputs and reads back its result and carry, one ALU operation per clock.
- Uses a request/response valid-ready handshake on the core side.
- Holds the 16-bit working state: accumulator plus shifting operand register.

---
 rtl/alu_pkg.sv | 26 ++
 rtl/alu_muldiv_seq_if.sv | 23 ++
 rtl/alu.sv | 40 ++++
 rtl/alu_muldiv_seq_step_logic.sv | 46 ++++
 rtl/alu_muldiv_seq.sv | 117 +++++++++++
 tb/tb_alu_muldiv_seq.sv | 245 ++++++++++++++++++++++++
 6 files changed

// File: rtl/alu_pkg.sv
// Shared ALU opcodes plus the encodings used by the multiply/divide sequencer.
package alu_pkg;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_LS  = 4'b0011;
  localparam logic [3:0] ALU_SRS = 4'b0100;
  localparam logic [3:0] ALU_URS = 4'b0101;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;
  localparam logic [3:0] ALU_ROR = 4'b1000;
  localparam logic [3:0] ALU_ROL = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_DONE = 2'd2
  } seq_state_t;

  typedef enum logic {
    OP_MUL = 1'b0,
    OP_DIV = 1'b1
  } md_op_t;

endpackage

// File: rtl/alu_muldiv_seq_if.sv
// Core-side request/response handshake of the multiply/divide sequencer.
interface alu_muldiv_seq_if;
  logic       req_valid;
  logic       req_ready;
  logic       req_op;
  logic [7:0] req_a;
  logic [7:0] req_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_hi;
  logic [7:0] rsp_lo;
  logic       rsp_err;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_err
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_hi, rsp_lo, rsp_err
  );
endinterface

// File: rtl/alu.sv
// 8-bit combinational ALU shared by the core and the multiply/divide sequencer.
module alu
  import alu_pkg::*;
(
  input  logic [7:0] ina,
  input  logic [7:0] inb,
  input  logic [3:0] op,
  input  logic [4:0] shamt,
  output logic [7:0] out,
  output logic       cr
);

  logic [8:0]  sum;
  logic [15:0] dbl;
  logic [15:0] ror_v;
  logic [15:0] rol_v;

  always_comb begin
    sum   = {1'b0, ina} + {1'b0, inb};
    dbl   = {ina, ina};
    ror_v = dbl >> shamt[2:0];
    rol_v = dbl << shamt[2:0];
    out   = 8'h00;
    cr    = 1'b0;
    case (op)
      ALU_ADD: begin out = sum[7:0]; cr = sum[8]; end
      ALU_SUB: begin out = ina - inb; cr = (ina >= inb); end
      ALU_AND: out = ina & inb;
      ALU_OR:  out = ina | inb;
      ALU_SLT: out = {7'd0, ($signed(ina) < $signed(inb))};
      ALU_LS:  out = ina << shamt;
      ALU_URS: out = ina >> shamt;
      ALU_SRS: out = 8'($signed(ina) >>> shamt);
      ALU_ROR: out = ror_v[7:0];
      ALU_ROL: out = rol_v[15:8];
      default: out = 8'h00;
    endcase
  end

endmodule

// File: rtl/alu_muldiv_seq_step_logic.sv
// One shift-add (MUL) or restoring-divide (DIV) iteration: ALU drive and next H/L.
module muldiv_step_logic
  import alu_pkg::*;
(
  input  md_op_t     op,
  input  logic [7:0] h,
  input  logic [7:0] l,
  input  logic [7:0] m,
  input  logic [7:0] alu_out,
  input  logic       alu_cr,
  output logic [7:0] alu_ina,
  output logic [7:0] alu_inb,
  output logic [3:0] alu_op,
  output logic [7:0] h_nxt,
  output logic [7:0] l_nxt
);

  logic [8:0] s;
  logic       ok;

  always_comb begin
    s       = {h, l[7]};
    ok      = 1'b0;
    alu_ina = 8'h00;
    alu_inb = 8'h00;
    alu_op  = ALU_ADD;
    h_nxt   = h;
    l_nxt   = l;
    if (op == OP_MUL) begin
      alu_op  = ALU_ADD;
      alu_ina = h;
      alu_inb = l[0] ? m : 8'h00;
      h_nxt   = {alu_cr, alu_out[7:1]};
      l_nxt   = {alu_out[0], l[7:1]};
    end else begin
      // S[8] set means the shifted remainder already exceeds any 8-bit divisor
      alu_op  = ALU_SUB;
      alu_ina = s[7:0];
      alu_inb = m;
      ok      = s[8] | alu_cr;
      h_nxt   = ok ? alu_out : s[7:0];
      l_nxt   = {l[6:0], ok};
    end
  end

endmodule

// File: rtl/alu_muldiv_seq.sv
// Multi-cycle 8x8 unsigned multiply / 8/8 unsigned divide sequencer driving the shared ALU.
module alu_muldiv_seq
  import alu_pkg::*;
#(
  parameter logic [7:0] DIVZ_QUOT   = 8'hFF,
  parameter bit         DIVZ_ERR_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  alu_muldiv_seq_if.slave   bus,
  output logic              busy,
  output logic [7:0]        alu_ina,
  output logic [7:0]        alu_inb,
  output logic [3:0]        alu_op,
  output logic [4:0]        alu_shamt,
  input  logic [7:0]        alu_out,
  input  logic              alu_cr
);

  seq_state_t state, state_nxt;
  md_op_t     op_q;
  logic [2:0] cnt;
  logic [7:0] h, l, m;
  logic       err_q;
  logic       accept, divz;
  logic [7:0] step_ina, step_inb, h_nxt, l_nxt;
  logic [3:0] step_op;

  muldiv_step_logic u_step (
    .op      (op_q),
    .h       (h),
    .l       (l),
    .m       (m),
    .alu_out (alu_out),
    .alu_cr  (alu_cr),
    .alu_ina (step_ina),
    .alu_inb (step_inb),
    .alu_op  (step_op),
    .h_nxt   (h_nxt),
    .l_nxt   (l_nxt)
  );

  assign divz = (md_op_t'(bus.req_op) == OP_DIV) && (bus.req_b == 8'h00);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    accept        = 1'b0;
    bus.req_ready = (state == S_IDLE);
    bus.rsp_valid = (state == S_DONE);
    busy          = (state != S_IDLE);
    alu_ina       = 8'h00;
    alu_inb       = 8'h00;
    alu_op        = ALU_ADD;
    alu_shamt     = 5'd0;
    case (state)
      S_IDLE: begin
        if (bus.req_valid) begin
          accept    = 1'b1;
          state_nxt = divz ? S_DONE : S_STEP;
        end
      end
      S_STEP: begin
        alu_ina = step_ina;
        alu_inb = step_inb;
        alu_op  = step_op;
        if (cnt == 3'd7) state_nxt = S_DONE;
      end
      S_DONE: begin
        if (bus.rsp_ready) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_q  <= OP_MUL;
      cnt   <= 3'd0;
      h     <= 8'h00;
      l     <= 8'h00;
      m     <= 8'h00;
      err_q <= 1'b0;
    end else if (accept) begin
      op_q  <= md_op_t'(bus.req_op);
      cnt   <= 3'd0;
      err_q <= divz;
      if (divz) begin
        h <= bus.req_a;
        l <= DIVZ_QUOT;
        m <= 8'h00;
      end else if (md_op_t'(bus.req_op) == OP_DIV) begin
        h <= 8'h00;
        l <= bus.req_a;
        m <= bus.req_b;
      end else begin
        h <= 8'h00;
        l <= bus.req_b;
        m <= bus.req_a;
      end
    end else if (state == S_STEP) begin
      h   <= h_nxt;
      l   <= l_nxt;
      cnt <= cnt + 3'd1;
    end
  end

  // H/L are only written on accept and in STEP, so DONE data stays put under backpressure
  assign bus.rsp_hi  = h;
  assign bus.rsp_lo  = l;
  assign bus.rsp_err = DIVZ_ERR_EN ? err_q : 1'b0;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// Directed bench for alu_muldiv_seq wired to the shared ALU.
module tb_alu_muldiv_seq;
  import alu_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       busy;
  logic [7:0] alu_ina, alu_inb, alu_out;
  logic [3:0] alu_op;
  logic [4:0] alu_shamt;
  logic       alu_cr;

  int   checks = 0;
  int   errors = 0;
  logic mon_en = 1'b0;
  logic cur_op = 1'b0;

  always #5 clk = ~clk;

  alu_muldiv_seq_if bus ();

  alu_muldiv_seq #(.DIVZ_QUOT(8'hFF), .DIVZ_ERR_EN(1'b1)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .busy      (busy),
    .alu_ina   (alu_ina),
    .alu_inb   (alu_inb),
    .alu_op    (alu_op),
    .alu_shamt (alu_shamt),
    .alu_out   (alu_out),
    .alu_cr    (alu_cr)
  );

  alu u_alu (
    .ina   (alu_ina),
    .inb   (alu_inb),
    .op    (alu_op),
    .shamt (alu_shamt),
    .out   (alu_out),
    .cr    (alu_cr)
  );

  typedef struct {
    logic       op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] hi;
    logic [7:0] lo;
    logic       err;
    int         lat;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ALU drive: op depends on the operation in STEP, reset values everywhere else
  always @(negedge clk) begin
    logic [3:0] eop;
    if (mon_en) begin
      eop = (busy && !bus.rsp_valid) ? (cur_op ? ALU_SUB : ALU_ADD) : ALU_ADD;
      chk("alu_op", 32'(alu_op), 32'(eop));
      chk("alu_shamt", 32'(alu_shamt), 32'd0);
      if (!busy || bus.rsp_valid) begin
        chk("alu_ina_idle", 32'(alu_ina), 32'd0);
        chk("alu_inb_idle", 32'(alu_inb), 32'd0);
      end
    end
  end

  task automatic wait_rsp(output int lat);
    lat = 0;
    while (!bus.rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic retire(input string nm);
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk({nm, "_retired_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({nm, "_retired_busy"}, 32'(busy), 32'd0);
  endtask

  task automatic run_txn(input string nm, input logic op, input logic [7:0] a, input logic [7:0] b,
                         input logic [7:0] ehi, input logic [7:0] elo, input logic eerr, input int elat);
    int lat;
    int guard;
    @(negedge clk);
    guard = 0;
    while (!bus.req_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    chk({nm, "_req_ready"}, 32'(bus.req_ready), 32'd1);
    cur_op        = op;
    bus.req_op    = op;
    bus.req_a     = a;
    bus.req_b     = b;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    bus.req_a     = 8'h5A;
    bus.req_b     = 8'hA5;
    wait_rsp(lat);
    chk({nm, "_latency"}, 32'(lat), 32'(elat));
    chk({nm, "_hi"}, 32'(bus.rsp_hi), 32'(ehi));
    chk({nm, "_lo"}, 32'(bus.rsp_lo), 32'(elo));
    chk({nm, "_err"}, 32'(bus.rsp_err), 32'(eerr));
    chk({nm, "_busy"}, 32'(busy), 32'd1);
    chk({nm, "_no_ready"}, 32'(bus.req_ready), 32'd0);
    retire(nm);
  endtask

  initial begin
    int lat;
    vecs[0]  = '{1'b0, 8'd13,  8'd11,  8'h00, 8'h8F, 1'b0, 8};
    vecs[1]  = '{1'b0, 8'd255, 8'd255, 8'hFE, 8'h01, 1'b0, 8};
    vecs[2]  = '{1'b0, 8'd0,   8'd200, 8'h00, 8'h00, 1'b0, 8};
    vecs[3]  = '{1'b0, 8'd16,  8'd16,  8'h01, 8'h00, 1'b0, 8};
    vecs[4]  = '{1'b0, 8'd128, 8'd2,   8'h01, 8'h00, 1'b0, 8};
    vecs[5]  = '{1'b1, 8'd200, 8'd7,   8'h04, 8'h1C, 1'b0, 8};
    vecs[6]  = '{1'b1, 8'd255, 8'd128, 8'h7F, 8'h01, 1'b0, 8};
    vecs[7]  = '{1'b1, 8'd42,  8'd0,   8'h2A, 8'hFF, 1'b1, 0};
    vecs[8]  = '{1'b1, 8'd5,   8'd9,   8'h05, 8'h00, 1'b0, 8};
    vecs[9]  = '{1'b1, 8'd255, 8'd1,   8'h00, 8'hFF, 1'b0, 8};
    vecs[10] = '{1'b1, 8'd100, 8'd10,  8'h00, 8'h0A, 1'b0, 8};

    rst           = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_op    = 1'b0;
    bus.req_a     = 8'h00;
    bus.req_b     = 8'h00;
    bus.rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_hi", 32'(bus.rsp_hi), 32'd0);
    chk("rst_lo", 32'(bus.rsp_lo), 32'd0);
    chk("rst_err", 32'(bus.rsp_err), 32'd0);
    chk("rst_alu_op", 32'(alu_op), 32'(ALU_ADD));
    rst    = 1'b0;
    mon_en = 1'b1;

    for (int i = 0; i < 11; i++)
      run_txn($sformatf("v%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
              vecs[i].hi, vecs[i].lo, vecs[i].err, vecs[i].lat);

    // backpressure: DONE held for 20 cycles while a competing request is offered
    @(negedge clk);
    chk("bp_start_ready", 32'(bus.req_ready), 32'd1);
    cur_op        = 1'b0;
    bus.req_op    = 1'b0;
    bus.req_a     = 8'd6;
    bus.req_b     = 8'd7;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_a = 8'd3;
    bus.req_b = 8'd4;
    wait_rsp(lat);
    chk("bp_latency", 32'(lat), 32'd8);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      chk("bp_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_hi", 32'(bus.rsp_hi), 32'h00);
      chk("bp_lo", 32'(bus.rsp_lo), 32'h2A);
      chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    chk("bp_retire_busy", 32'(busy), 32'd0);
    chk("bp_retire_ready", 32'(bus.req_ready), 32'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("bp_next_accepted", 32'(busy), 32'd1);
    wait_rsp(lat);
    chk("bp_next_latency", 32'(lat), 32'd8);
    chk("bp_next_hi", 32'(bus.rsp_hi), 32'h00);
    chk("bp_next_lo", 32'(bus.rsp_lo), 32'h0C);
    retire("bp_next");

    // reset in the middle of a multiply, at cnt = 4
    @(negedge clk);
    cur_op        = 1'b0;
    bus.req_op    = 1'b0;
    bus.req_a     = 8'd200;
    bus.req_b     = 8'd3;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("mrst_ready", 32'(bus.req_ready), 32'd1);
    chk("mrst_hi", 32'(bus.rsp_hi), 32'd0);
    chk("mrst_lo", 32'(bus.rsp_lo), 32'd0);
    chk("mrst_alu_op", 32'(alu_op), 32'(ALU_ADD));
    chk("mrst_alu_ina", 32'(alu_ina), 32'd0);
    chk("mrst_alu_inb", 32'(alu_inb), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_txn("after_rst", 1'b0, 8'd3, 8'd5, 8'h00, 8'h0F, 1'b0, 8);

    // reset while a divide-by-zero response waits in DONE
    @(negedge clk);
    cur_op        = 1'b1;
    bus.req_op    = 1'b1;
    bus.req_a     = 8'd7;
    bus.req_b     = 8'd0;
    bus.req_valid = 1'b1;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    chk("dz_valid", 32'(bus.rsp_valid), 32'd1);
    chk("dz_err", 32'(bus.rsp_err), 32'd1);
    rst = 1'b1;
    #1;
    chk("dzrst_valid", 32'(bus.rsp_valid), 32'd0);
    chk("dzrst_err", 32'(bus.rsp_err), 32'd0);
    chk("dzrst_hi", 32'(bus.rsp_hi), 32'd0);
    chk("dzrst_lo", 32'(bus.rsp_lo), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_txn("final", 1'b1, 8'd9, 8'd2, 8'h01, 8'h04, 1'b0, 8);

    mon_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
